// File: rtl/nec_ir_transmit.sv
// NEC infrared transmitter: leader, 32 data bits LSB first, stop mark and inter-frame gap.
// Optional 50% duty carrier on ir_tx when NEC_TX_CARRIER_EN is defined; baseband otherwise.
module nec_ir_transmit #(
  parameter int unsigned UNIT_CYCLES = 28125,
  parameter int unsigned CARRIER_DIV = 1316,
  parameter int unsigned GAP_UNITS   = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] data_to_send,
  output logic        ir_tx,
  output logic        ir_env
);

  if (UNIT_CYCLES < 1 || UNIT_CYCLES > 32768) begin : g_bad_unit
    $error("UNIT_CYCLES must fit in 15 bits");
  end
  if (CARRIER_DIV < 2 || (CARRIER_DIV % 2) != 0) begin : g_bad_div
    $error("CARRIER_DIV must be even and at least 2");
  end
  if (GAP_UNITS < 1 || GAP_UNITS > 128) begin : g_bad_gap
    $error("GAP_UNITS must be 1..128");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap
  } state_e;

  localparam logic [14:0] UnitLast = 15'(UNIT_CYCLES - 1);
  localparam logic [6:0]  GapLoad  = 7'(GAP_UNITS - 1);

  state_e      r_state, w_state_nxt;
  logic [14:0] r_cycle, w_cycle_nxt;
  logic [6:0]  r_unit, w_unit_nxt;
  logic [4:0]  r_bit_idx, w_bit_idx_nxt;
  logic [31:0] r_shift, w_shift_nxt;
  logic        r_ready, r_env, r_tx;
  logic        w_unit_end, w_state_end;
  logic        w_env_nxt, w_ready_nxt, w_tx_nxt;

  assign w_unit_end  = (r_cycle == UnitLast);
  assign w_state_end = w_unit_end && (r_unit == 7'd0);

  // Unit counter holds remaining units minus one; it is reloaded on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_cycle_nxt   = r_cycle;
    w_unit_nxt    = r_unit;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;

    if (r_state != StIdle) begin
      w_cycle_nxt = w_unit_end ? 15'd0 : r_cycle + 15'd1;
      if (w_unit_end && r_unit != 7'd0) begin
        w_unit_nxt = r_unit - 7'd1;
      end
    end

    unique case (r_state)
      StIdle: begin
        if (valid && r_ready) begin
          w_state_nxt   = StLeadMark;
          w_shift_nxt   = data_to_send;
          w_bit_idx_nxt = 5'd0;
          w_unit_nxt    = 7'd15;
          w_cycle_nxt   = 15'd0;
        end
      end
      StLeadMark: begin
        if (w_state_end) begin
          w_state_nxt = StLeadSpace;
          w_unit_nxt  = 7'd7;
        end
      end
      StLeadSpace: begin
        if (w_state_end) begin
          w_state_nxt   = StBitMark;
          w_unit_nxt    = 7'd0;
          w_bit_idx_nxt = 5'd0;
        end
      end
      StBitMark: begin
        if (w_state_end) begin
          w_state_nxt = StBitSpace;
          w_unit_nxt  = r_shift[0] ? 7'd2 : 7'd0;
        end
      end
      StBitSpace: begin
        if (w_state_end) begin
          w_unit_nxt = 7'd0;
          if (r_bit_idx != 5'd31) begin
            w_state_nxt   = StBitMark;
            w_shift_nxt   = {1'b0, r_shift[31:1]};
            w_bit_idx_nxt = r_bit_idx + 5'd1;
          end else begin
            w_state_nxt = StStopMark;
          end
        end
      end
      StStopMark: begin
        if (w_state_end) begin
          w_state_nxt = StGap;
          w_unit_nxt  = GapLoad;
        end
      end
      StGap: begin
        if (w_state_end) begin
          w_state_nxt = StIdle;
          w_unit_nxt  = 7'd0;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_unit_nxt  = 7'd0;
        w_cycle_nxt = 15'd0;
      end
    endcase
  end

  assign w_env_nxt   = (w_state_nxt == StLeadMark) || (w_state_nxt == StBitMark) ||
                       (w_state_nxt == StStopMark);
  assign w_ready_nxt = (w_state_nxt == StIdle);

`ifdef NEC_TX_CARRIER_EN
  localparam int unsigned CarW = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CarW-1:0] CarLast = CarW'(CARRIER_DIV - 1);
  localparam logic [CarW-1:0] CarHalf = CarW'(CARRIER_DIV / 2);

  logic [CarW-1:0] r_car, w_car_nxt;
  logic            w_mark_entry;

  // Restarting on mark entry makes every mark open with a high half-period.
  assign w_mark_entry = w_env_nxt && (w_state_nxt != r_state);

  always_comb begin
    w_car_nxt = r_car;
    if (w_mark_entry || !w_env_nxt) begin
      w_car_nxt = '0;
    end else if (r_car == CarLast) begin
      w_car_nxt = '0;
    end else begin
      w_car_nxt = r_car + 1'b1;
    end
  end

  assign w_tx_nxt = w_env_nxt && (w_car_nxt < CarHalf);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_car <= '0;
    end else begin
      r_car <= w_car_nxt;
    end
  end
`else
  assign w_tx_nxt = w_env_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cycle   <= 15'd0;
      r_unit    <= 7'd0;
      r_bit_idx <= 5'd0;
      r_shift   <= 32'd0;
      r_ready   <= 1'b1;
      r_env     <= 1'b0;
      r_tx      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cycle   <= w_cycle_nxt;
      r_unit    <= w_unit_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_ready   <= w_ready_nxt;
      r_env     <= w_env_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  assign ready  = r_ready;
  assign ir_env = r_env;
  assign ir_tx  = r_tx;

endmodule
